// File: rtl/mux_2to1_pkg.sv
// Shared definitions for the two-lane merge path (mux_2to1 / demux_1to2).
// Default widths, lane identifiers and the round-robin pick helper.
package mux_2to1_pkg;

    localparam int BW_DEF    = 8;
    localparam int DEPTH_DEF = 4;
    localparam int AW_DEF    = 2;

    typedef enum logic {
        LANE0 = 1'b0,
        LANE1 = 1'b1
    } lane_e;

    // Round-robin choice on the current occupancy.
    // With both lanes busy the lane not served last wins.
    function automatic lane_e rr_pick(
        input lane_e last,
        input logic  ne0,
        input logic  ne1
    );
        lane_e pick;
        pick = last;
        unique case (1'b1)
            (ne0 && ne1):  pick = (last == LANE0) ? LANE1 : LANE0;
            (ne0 && !ne1): pick = LANE0;
            (!ne0 && ne1): pick = LANE1;
            default:       pick = last;
        endcase
        return pick;
    endfunction

endpackage

// File: rtl/mux_2to1_fifo_sync.sv
// Per-lane synchronous FIFO with combinational head word.
// Storage is not reset; pointers and count define what is valid.
module fifo_sync
    import mux_2to1_pkg::*;
#(
    parameter int BW    = BW_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic          clk,
    input  logic          reset_L,
    input  logic          wr,
    input  logic [BW-1:0] din,
    input  logic          rd,
    output logic [BW-1:0] dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    localparam logic [AW:0] L_DEPTH = (AW+1)'(DEPTH);

    logic [BW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wrptr;
    logic [AW-1:0] r_rdptr;
    logic [AW:0]   r_count;

    logic w_full;
    logic w_empty;
    logic w_rd;
    logic w_wr;

    assign w_full  = (r_count == L_DEPTH);
    assign w_empty = (r_count == '0);

    // A pop frees the slot the simultaneous write lands in when full.
    assign w_rd = rd & ~w_empty;
    assign w_wr = wr & (~w_full | w_rd);

    assign dout  = r_mem[r_rdptr];
    assign full  = w_full;
    assign empty = w_empty;
    assign count = r_count;

    // Data storage, written at the write pointer.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wrptr] <= din;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_wrptr <= '0;
            r_rdptr <= '0;
        end else begin
            if (w_wr) begin
                r_wrptr <= r_wrptr + 1'b1;
            end
            if (w_rd) begin
                r_rdptr <= r_rdptr + 1'b1;
            end
        end
    end

    // Occupancy: write and pop together leave it unchanged.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_count <= '0;
        end else begin
            unique case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    a_no_empty_read: assert property (
        @(posedge clk) disable iff (!reset_L) !(rd && w_empty)
    );

    a_count_bound: assert property (
        @(posedge clk) disable iff (!reset_L) r_count <= L_DEPTH
    );

endmodule

// File: rtl/mux_2to1.sv
// Two-lane to one-stream merger: lane FIFOs, round-robin drain,
// registered output word and sticky per-lane overflow flags.
module mux_2to1
    import mux_2to1_pkg::*;
#(
    parameter int BW    = BW_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic          clk,
    input  logic          reset_L,
    input  logic [BW-1:0] data_in0,
    input  logic          valid_in0,
    input  logic [BW-1:0] data_in1,
    input  logic          valid_in1,
    output logic          full0,
    output logic          full1,
    output logic [BW-1:0] data_out,
    output logic          valid_out,
    output logic          err_ovf0,
    output logic          err_ovf1
);

    localparam logic [AW:0] L_DEPTH = (AW+1)'(DEPTH);

    lane_e         r_last_sel;
    logic [BW-1:0] r_data;
    logic          r_valid;
    logic          r_err0;
    logic          r_err1;

    logic [BW-1:0] w_dout0;
    logic [BW-1:0] w_dout1;
    logic          w_full0;
    logic          w_full1;
    logic          w_empty0;
    logic          w_empty1;
    logic [AW:0]   w_count0;
    logic [AW:0]   w_count1;

    lane_e         w_sel;
    logic          w_pop;
    logic          w_rd0;
    logic          w_rd1;
    logic          w_wr0;
    logic          w_wr1;
    logic          w_drop0;
    logic          w_drop1;
    logic [BW-1:0] w_head;

    fifo_sync #(
        .BW    (BW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo0 (
        .clk     (clk),
        .reset_L (reset_L),
        .wr      (w_wr0),
        .din     (data_in0),
        .rd      (w_rd0),
        .dout    (w_dout0),
        .full    (w_full0),
        .empty   (w_empty0),
        .count   (w_count0)
    );

    fifo_sync #(
        .BW    (BW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo1 (
        .clk     (clk),
        .reset_L (reset_L),
        .wr      (w_wr1),
        .din     (data_in1),
        .rd      (w_rd1),
        .dout    (w_dout1),
        .full    (w_full1),
        .empty   (w_empty1),
        .count   (w_count1)
    );

    // Arbitration on pre-edge occupancy; one lane drained per cycle.
    always_comb begin
        w_pop  = ~w_empty0 | ~w_empty1;
        w_sel  = rr_pick(r_last_sel, ~w_empty0, ~w_empty1);
        w_rd0  = w_pop & (w_sel == LANE0);
        w_rd1  = w_pop & (w_sel == LANE1);
        w_head = (w_sel == LANE1) ? w_dout1 : w_dout0;
    end

    // A full lane still takes a word when it is drained on the same edge.
    always_comb begin
        w_wr0   = valid_in0 & (~w_full0 | w_rd0);
        w_wr1   = valid_in1 & (~w_full1 | w_rd1);
        w_drop0 = valid_in0 & w_full0 & ~w_rd0;
        w_drop1 = valid_in1 & w_full1 & ~w_rd1;
    end

    // Remember the served lane; lane 0 wins the first contest.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_last_sel <= LANE1;
        end else if (w_pop) begin
            r_last_sel <= w_sel;
        end
    end

    // Output register: data holds between pops, valid marks fresh words.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_pop;
            if (w_pop) begin
                r_data <= w_head;
            end
        end
    end

    // Overflow flags stay set until the next reset.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_err0 <= 1'b0;
            r_err1 <= 1'b0;
        end else begin
            r_err0 <= r_err0 | w_drop0;
            r_err1 <= r_err1 | w_drop1;
        end
    end

    assign full0     = (w_count0 == L_DEPTH);
    assign full1     = (w_count1 == L_DEPTH);
    assign data_out  = r_data;
    assign valid_out = r_valid;
    assign err_ovf0  = r_err0;
    assign err_ovf1  = r_err1;

    a_single_pop: assert property (
        @(posedge clk) disable iff (!reset_L) !(w_rd0 && w_rd1)
    );

endmodule

// File: tb/tb_mux_2to1.sv
// Directed bench for mux_2to1: reset, alternate feed, single lane,
// overflow, full-with-pop, round trip and asynchronous mid-stream reset.
module tb_mux_2to1;

    logic       clk;
    logic       reset_L;
    logic [7:0] data_in0;
    logic       valid_in0;
    logic [7:0] data_in1;
    logic       valid_in1;
    logic       full0;
    logic       full1;
    logic [7:0] data_out;
    logic       valid_out;
    logic       err_ovf0;
    logic       err_ovf1;

    int n_err = 0;
    int n_chk = 0;

    mux_2to1 #(
        .BW    (8),
        .DEPTH (4),
        .AW    (2)
    ) dut (
        .clk       (clk),
        .reset_L   (reset_L),
        .data_in0  (data_in0),
        .valid_in0 (valid_in0),
        .data_in1  (data_in1),
        .valid_in1 (valid_in1),
        .full0     (full0),
        .full1     (full1),
        .data_out  (data_out),
        .valid_out (valid_out),
        .err_ovf0  (err_ovf0),
        .err_ovf1  (err_ovf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        valid_in0 = 1'b0;
        valid_in1 = 1'b0;
        data_in0  = 8'h00;
        data_in1  = 8'h00;
    endtask

    task automatic test_reset();
        reset_L = 1'b0;
        idle_inputs();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_chk++;
            if (data_out !== 8'h00 || valid_out !== 1'b0 ||
                full0 !== 1'b0 || full1 !== 1'b0 ||
                err_ovf0 !== 1'b0 || err_ovf1 !== 1'b0) begin
                n_err++;
                $display("FAIL reset[%0d]: data=%h v=%b full=%b%b err=%b%b, required 00 0 00 00",
                         c, data_out, valid_out, full0, full1, err_ovf0, err_ovf1);
            end
            data_in0  = 8'($urandom);
            data_in1  = 8'($urandom);
            valid_in0 = 1'($urandom);
            valid_in1 = 1'($urandom);
        end
        @(negedge clk);
        idle_inputs();
        reset_L = 1'b1;
    endtask

    task automatic test_alternate();
        logic [7:0] exp [6] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            n_chk++;
            if (c >= 2 && c <= 7) begin
                if (valid_out !== 1'b1 || data_out !== exp[c-2]) begin
                    n_err++;
                    $display("FAIL alt[%0d]: data=%h v=%b, required %h 1",
                             c, data_out, valid_out, exp[c-2]);
                end
            end else if (valid_out !== 1'b0) begin
                n_err++;
                $display("FAIL alt_idle[%0d]: v=%b, required 0", c, valid_out);
            end
            if (c < 3) begin
                valid_in0 = 1'b1;
                data_in0  = 8'(2 * c);
                valid_in1 = 1'b1;
                data_in1  = 8'(2 * c + 1);
            end else begin
                idle_inputs();
            end
        end
    endtask

    task automatic test_single_lane();
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            n_chk++;
            if (c >= 2 && c <= 5) begin
                if (valid_out !== 1'b1 || data_out !== 8'(8'hA0 + c - 2)) begin
                    n_err++;
                    $display("FAIL single[%0d]: data=%h v=%b, required %h 1",
                             c, data_out, valid_out, 8'(8'hA0 + c - 2));
                end
            end else if (valid_out !== 1'b0) begin
                n_err++;
                $display("FAIL single_idle[%0d]: v=%b, required 0", c, valid_out);
            end
            idle_inputs();
            if (c < 4) begin
                valid_in1 = 1'b1;
                data_in1  = 8'(8'hA0 + c);
            end
        end
    endtask

    // Lane 0 words 0x40+n, lane 1 words 0x80+n, both every edge for 12 edges.
    task automatic test_overflow();
        logic [7:0] exp [19] = '{
            8'h40, 8'h80, 8'h41, 8'h81, 8'h42, 8'h82, 8'h43, 8'h83,
            8'h44, 8'h84, 8'h45, 8'h85, 8'h46, 8'h86, 8'h47, 8'h88,
            8'h49, 8'h8A, 8'h4B};
        for (int c = 0; c < 23; c++) begin
            @(negedge clk);
            n_chk++;
            if (c >= 2 && c <= 20) begin
                if (valid_out !== 1'b1 || data_out !== exp[c-2]) begin
                    n_err++;
                    $display("FAIL ovf_data[%0d]: data=%h v=%b, required %h 1",
                             c, data_out, valid_out, exp[c-2]);
                end
            end else if (valid_out !== 1'b0) begin
                n_err++;
                $display("FAIL ovf_idle[%0d]: v=%b, required 0", c, valid_out);
            end
            n_chk++;
            if (err_ovf0 !== (c >= 9) || err_ovf1 !== (c >= 8)) begin
                n_err++;
                $display("FAIL ovf_err[%0d]: err=%b%b, required %b%b",
                         c, err_ovf0, err_ovf1, (c >= 9), (c >= 8));
            end
            n_chk++;
            if (full0 !== (c >= 7 && c <= 13) || full1 !== (c >= 6 && c <= 12)) begin
                n_err++;
                $display("FAIL ovf_full[%0d]: full=%b%b, required %b%b",
                         c, full0, full1, (c >= 7 && c <= 13), (c >= 6 && c <= 12));
            end
            if (c < 12) begin
                valid_in0 = 1'b1;
                data_in0  = 8'(8'h40 + c);
                valid_in1 = 1'b1;
                data_in1  = 8'(8'h80 + c);
            end else begin
                idle_inputs();
            end
        end
    endtask

    task automatic test_full_pop();
        logic [7:0] exp [15] = '{
            8'h40, 8'h80, 8'h41, 8'h81, 8'h42, 8'h82, 8'h43, 8'h83,
            8'h44, 8'h84, 8'h45, 8'h85, 8'h46, 8'h86, 8'h47};
        @(negedge clk);
        n_chk++;
        if (err_ovf0 !== 1'b1 || err_ovf1 !== 1'b1) begin
            n_err++;
            $display("FAIL sticky: err=%b%b, required 11", err_ovf0, err_ovf1);
        end
        reset_L = 1'b0;
        @(negedge clk);
        reset_L = 1'b1;
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            n_chk++;
            if (c >= 2 && c <= 16) begin
                if (valid_out !== 1'b1 || data_out !== exp[c-2]) begin
                    n_err++;
                    $display("FAIL fp_data[%0d]: data=%h v=%b, required %h 1",
                             c, data_out, valid_out, exp[c-2]);
                end
            end else if (valid_out !== 1'b0) begin
                n_err++;
                $display("FAIL fp_idle[%0d]: v=%b, required 0", c, valid_out);
            end
            n_chk++;
            if (err_ovf0 !== 1'b0 || err_ovf1 !== 1'b0) begin
                n_err++;
                $display("FAIL fp_err[%0d]: err=%b%b, required 00", c, err_ovf0, err_ovf1);
            end
            if (c == 7 || c == 8) begin
                n_chk++;
                if (full0 !== 1'b1) begin
                    n_err++;
                    $display("FAIL fp_full[%0d]: full0=%b, required 1", c, full0);
                end
            end
            idle_inputs();
            if (c < 8) begin
                valid_in0 = 1'b1;
                data_in0  = 8'(8'h40 + c);
            end
            if (c < 7) begin
                valid_in1 = 1'b1;
                data_in1  = 8'(8'h80 + c);
            end
        end
    endtask

    // Upstream splitter behaviour: word n goes to lane n%2, one word per edge.
    task automatic test_round_trip();
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            n_chk++;
            if (c >= 2) begin
                if (valid_out !== 1'b1 || data_out !== 8'(8'h10 + c - 2)) begin
                    n_err++;
                    $display("FAIL rt[%0d]: data=%h v=%b, required %h 1",
                             c, data_out, valid_out, 8'(8'h10 + c - 2));
                end
            end else if (valid_out !== 1'b0) begin
                n_err++;
                $display("FAIL rt_idle[%0d]: v=%b, required 0", c, valid_out);
            end
            idle_inputs();
            if (c < 16) begin
                if (c % 2 == 0) begin
                    valid_in0 = 1'b1;
                    data_in0  = 8'(8'h10 + c);
                end else begin
                    valid_in1 = 1'b1;
                    data_in1  = 8'(8'h10 + c);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            idle_inputs();
            if (c < 4) begin
                if (c % 2 == 0) begin
                    valid_in0 = 1'b1;
                    data_in0  = 8'(8'h20 + c);
                end else begin
                    valid_in1 = 1'b1;
                    data_in1  = 8'(8'h20 + c);
                end
            end
        end
        n_chk++;
        if (valid_out !== 1'b1 || data_out !== 8'h22) begin
            n_err++;
            $display("FAIL mid_pre: data=%h v=%b, required 22 1", data_out, valid_out);
        end
        #2;
        reset_L = 1'b0;
        #1;
        n_chk++;
        if (data_out !== 8'h00 || valid_out !== 1'b0 || full0 !== 1'b0 || full1 !== 1'b0) begin
            n_err++;
            $display("FAIL mid_async: data=%h v=%b full=%b%b, required 00 0 00",
                     data_out, valid_out, full0, full1);
        end
        @(negedge clk);
        reset_L = 1'b1;
        @(negedge clk);
        n_chk++;
        if (valid_out !== 1'b0) begin
            n_err++;
            $display("FAIL mid_discard: v=%b data=%h, required 0", valid_out, data_out);
        end
        valid_in0 = 1'b1;
        data_in0  = 8'h31;
        valid_in1 = 1'b1;
        data_in1  = 8'h32;
        @(negedge clk);
        idle_inputs();
        n_chk++;
        if (valid_out !== 1'b0) begin
            n_err++;
            $display("FAIL fresh_lat: v=%b, required 0", valid_out);
        end
        @(negedge clk);
        n_chk++;
        if (valid_out !== 1'b1 || data_out !== 8'h31) begin
            n_err++;
            $display("FAIL fresh0: data=%h v=%b, required 31 1", data_out, valid_out);
        end
        @(negedge clk);
        n_chk++;
        if (valid_out !== 1'b1 || data_out !== 8'h32) begin
            n_err++;
            $display("FAIL fresh1: data=%h v=%b, required 32 1", data_out, valid_out);
        end
        @(negedge clk);
        n_chk++;
        if (valid_out !== 1'b0 || data_out !== 8'h32) begin
            n_err++;
            $display("FAIL fresh_end: data=%h v=%b, required 32 0", data_out, valid_out);
        end
    endtask

    initial begin
        reset_L = 1'b0;
        idle_inputs();
        test_reset();
        test_alternate();
        test_single_lane();
        test_overflow();
        test_full_pop();
        test_round_trip();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
